// File: rtl/cargador_operandos.sv
// -----------------------------------------------------------------------------
// cargador_operandos
// Operand-loading stage ahead of the magnitude comparator. Two operands are
// taken in turn from the switches, one per press of a raw push-button. The
// button is synchronised and debounced here, and each debounced press yields
// a one-cycle capture pulse. `valido` is high while a complete A/B pair is
// held.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   sw      in   [WIDTH-1:0] operand switches (asynchronous, stable during press)
//   btn     in   raw push-button, active-high, bouncy, asynchronous
//   A       out  [WIDTH-1:0] registered operand A
//   B       out  [WIDTH-1:0] registered operand B
//   valido  out  high while A/B is a complete, current pair
//   estado  out  [1:0] FSM state: 00 ESPERA_A, 01 ESPERA_B, 10 LISTO
//
// Optional feature (macro CARGADOR_TIMEOUT_EN):
//   When defined, a half-loaded pair is abandoned after TIMEOUT_CYCLES idle
//   cycles in ESPERA_B. A is then cleared and the FSM returns to ESPERA_A.
//   When undefined, ESPERA_B waits indefinitely.
// -----------------------------------------------------------------------------
module cargador_operandos #(
   parameter int unsigned WIDTH           = 3,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw,
   input  logic             btn,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic             valido,
   output logic [1:0]       estado
);

   localparam int unsigned      CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ESPERA_A = 2'b00,
      ESPERA_B = 2'b01,
      LISTO    = 2'b10
   } estado_t;

   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   logic             deb_q, deb_d;
   logic             deb_dly_q, deb_dly_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   estado_t          estado_q, estado_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             valido_q, valido_d;
   logic             pulsa;

`ifdef CARGADOR_TIMEOUT_EN
   localparam int unsigned     TMO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] tmo_q, tmo_d;
`else
   // Timeout is not built; keep the parameter referenced.
   logic tmo_unused;
   assign tmo_unused = |TIMEOUT_CYCLES;
`endif

   always_comb begin
      s1_d      = btn;
      s2_d      = s1_q;
      deb_d     = deb_q;
      cnt_d     = cnt_q;
      deb_dly_d = deb_q;

      // The debounced level follows s2 only after DEBOUNCE_CYCLES consecutive
      // differing samples; any agreeing sample restarts the count.
      if (s2_q == deb_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         deb_d = s2_q;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end

      pulsa = deb_q & ~deb_dly_q;

      estado_d = estado_q;
      a_d      = a_q;
      b_d      = b_q;
      valido_d = valido_q;
`ifdef CARGADOR_TIMEOUT_EN
      tmo_d    = '0;
`endif

      if (pulsa) begin
         case (estado_q)
            ESPERA_A: begin
               a_d      = sw;
               valido_d = 1'b0;
               estado_d = ESPERA_B;
            end
            ESPERA_B: begin
               b_d      = sw;
               valido_d = 1'b1;
               estado_d = LISTO;
            end
            LISTO: begin
               a_d      = sw;
               valido_d = 1'b0;
               estado_d = ESPERA_B;
            end
            default: begin
               valido_d = 1'b0;
               estado_d = ESPERA_A;
            end
         endcase
`ifdef CARGADOR_TIMEOUT_EN
      end else if (estado_q == ESPERA_B) begin
         // Counter is held at zero outside ESPERA_B, so it starts from zero
         // on every entry. A pulse on the expiry edge is handled above.
         if (tmo_q == TMO_MAX) begin
            a_d      = '0;
            valido_d = 1'b0;
            estado_d = ESPERA_A;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         deb_q     <= 1'b0;
         deb_dly_q <= 1'b0;
         cnt_q     <= '0;
         estado_q  <= ESPERA_A;
         a_q       <= '0;
         b_q       <= '0;
         valido_q  <= 1'b0;
`ifdef CARGADOR_TIMEOUT_EN
         tmo_q     <= '0;
`endif
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         deb_q     <= deb_d;
         deb_dly_q <= deb_dly_d;
         cnt_q     <= cnt_d;
         estado_q  <= estado_d;
         a_q       <= a_d;
         b_q       <= b_d;
         valido_q  <= valido_d;
`ifdef CARGADOR_TIMEOUT_EN
         tmo_q     <= tmo_d;
`endif
      end
   end

   assign A      = a_q;
   assign B      = b_q;
   assign valido = valido_q;
   assign estado = estado_q;

endmodule

// File: tb/tb_cargador_operandos.sv
// -----------------------------------------------------------------------------
// tb_cargador_operandos
// Self-checking bench for cargador_operandos with DEBOUNCE_CYCLES=4 and
// TIMEOUT_CYCLES=8. A behavioural model describes the design in terms of
// sample windows and a load phase. It is compared against the outputs after
// every clock edge. Directed scenarios add fixed-value checks.
// Honours CARGADOR_TIMEOUT_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_cargador_operandos;

   localparam int unsigned W   = 3;
   localparam int unsigned DEB = 4;
   localparam int unsigned TMO = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         btn;
   logic [W-1:0] sw;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         valido;
   logic [1:0]   estado;

   int unsigned errors = 0;
   int unsigned checks = 0;

   cargador_operandos #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (DEB),
      .TIMEOUT_CYCLES  (TMO)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .sw     (sw),
      .btn    (btn),
      .A      (A),
      .B      (B),
      .valido (valido),
      .estado (estado)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   bit           m_s1, m_s2;      // button as seen after 1 and 2 samples
   bit           m_lvl, m_lvl_d;  // accepted button level, and one edge later
   bit           win[$];          // most recent DEB synchronised samples
   int unsigned  m_phase;         // 0 want A, 1 want B, 2 pair complete
   int unsigned  m_idle;          // edges spent waiting for B
   logic [W-1:0] m_a, m_b;

   task automatic model_step(input bit r, input bit b_in, input logic [W-1:0] s);
      bit press;
      bit all_diff;
      if (r) begin
         m_s1 = 0; m_s2 = 0; m_lvl = 0; m_lvl_d = 0;
         win.delete();
         m_phase = 0; m_idle = 0; m_a = '0; m_b = '0;
         return;
      end
      press = m_lvl && !m_lvl_d;
      if (press) begin
         case (m_phase)
            0: begin m_a = s; m_phase = 1; m_idle = 0; end
            1: begin m_b = s; m_phase = 2; end
            default: begin m_a = s; m_phase = 1; m_idle = 0; end
         endcase
      end else if (m_phase == 1) begin
`ifdef CARGADOR_TIMEOUT_EN
         if (m_idle + 1 == TMO) begin
            m_phase = 0;
            m_a     = '0;
         end else begin
            m_idle++;
         end
`endif
      end
      m_lvl_d = m_lvl;
      // The level flips once the last DEB samples all disagree with it.
      win.push_back(m_s2);
      if (win.size() > DEB) void'(win.pop_front());
      if (win.size() == DEB) begin
         all_diff = 1;
         foreach (win[i]) if (win[i] == m_lvl) all_diff = 0;
         if (all_diff) m_lvl = !m_lvl;
      end
      m_s2 = m_s1;
      m_s1 = b_in;
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(rst, btn, sw);
      #1;
      check("A", A, m_a);
      check("B", B, m_b);
      check("valido", valido, m_phase == 2);
      check("estado", estado, m_phase);
   endtask

   task automatic ticks(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) tick();
   endtask

   int unsigned  len;
   bit           lvl_r;
   int unsigned  n;

   initial begin
      // Reset while the button is held and the switches are all ones
      rst = 1'b1; btn = 1'b1; sw = 3'b111;
      ticks(2);
      check("rst_A", A, 0);
      check("rst_B", B, 0);
      check("rst_valido", valido, 0);
      check("rst_estado", estado, 0);
      rst = 1'b0; btn = 1'b0;
      ticks(DEB + 5);
      check("rst_nopress", estado, 0);

      // Bounce: 3 high / 1 low is always shorter than the filter
      sw = 3'b111;
      for (int i = 0; i < 20; i++) begin
         btn = (i % 4) < 3;
         tick();
      end
      btn = 1'b0;
      ticks(10);
      check("bounce_estado", estado, 0);
      check("bounce_A", A, 0);

      // Load A = 5, capture exactly DEB+3 edges after the first high sample
      sw = 3'b101; btn = 1'b1;
      ticks(DEB + 2);
      check("lat_early_A", A, 0);
      tick();
      check("lat_A", A, 5);
      check("lat_estado", estado, 1);
      ticks(3);
      btn = 1'b0;
      ticks(10);

      // Load B = 3
      sw = 3'b011; btn = 1'b1;
      ticks(10);
      btn = 1'b0;
      ticks(10);
      check("pair_B", B, 3);
      check("pair_valido", valido, 1);
      check("pair_estado", estado, 2);
      check("pair_a_gt_b", A > B, 1);

      // Reload from LISTO
      sw = 3'b010; btn = 1'b1;
      ticks(10);
      btn = 1'b0;
      ticks(10);
      check("reload_A", A, 2);
      check("reload_B", B, 3);
      check("reload_valido", valido, 0);
      check("reload_estado", estado, 1);
      for (int i = 0; i < 6; i++) begin
         sw = W'($urandom);
         tick();
      end
      check("sw_noload_A", A, 2);

      // Reset during debounce with the counter part-way, button kept held
      sw = 3'b110; btn = 1'b1;
      ticks(4);
      rst = 1'b1;
      tick();
      check("midrst_A", A, 0);
      check("midrst_B", B, 0);
      check("midrst_estado", estado, 0);
      rst = 1'b0;
      ticks(DEB + 2);
      check("redeb_wait", estado, 0);
      tick();
      check("redeb_A", A, 6);
      check("redeb_estado", estado, 1);

      // Idle in ESPERA_B
      btn = 1'b0;
`ifdef CARGADOR_TIMEOUT_EN
      ticks(TMO - 1);
      check("tmo_before", estado, 1);
      tick();
      check("tmo_estado", estado, 0);
      check("tmo_A", A, 0);
      check("tmo_valido", valido, 0);
      ticks(100 - TMO);
`else
      ticks(100);
      check("idle_estado", estado, 1);
      check("idle_A", A, 6);
`endif

      // Second press lands on the 8th edge in ESPERA_B (the expiry edge)
      rst = 1'b1; btn = 1'b0;
      tick();
      rst = 1'b0;
      ticks(12);
      for (int i = 1; i <= 16; i++) begin
         btn = (i <= 4) || (i >= 9);
         sw  = (i >= 9) ? 3'b001 : 3'b110;
         tick();
         if (i == 7) begin
            check("race_A", A, 6);
            check("race_loadA", estado, 1);
         end
         if (i == 14) check("race_wait", estado, 1);
         if (i == 15) begin
            check("race_estado", estado, 2);
            check("race_B", B, 1);
            check("race_valido", valido, 1);
         end
      end
      btn = 1'b0;
      ticks(10);

      // Random runs of button level, switch changes and occasional reset
      n = 0;
      while (n < 3000) begin
         len   = $urandom_range(1, 12);
         lvl_r = 1'($urandom_range(0, 1));
         for (int unsigned k = 0; k < len; k++) begin
            btn = lvl_r;
            if ($urandom_range(0, 3) == 0) sw = W'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            tick();
            n++;
         end
      end
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cargador_operandos.md
Name: cargador_operandos

Overview:
- Upstream operand-loading stage for the 3-bit magnitude comparator; feeds its A and B inputs.
- Captures two operands one after the other from board switches using a single raw push-button. The button is synchronised and debounced in this block.
- Asserts `valido` while a complete A/B pair is held stable, so the downstream comparator flags (igual/menor/mayor) are meaningful only while `valido`=1.

Parameters:
WIDTH, 3, operand width in bits; matches the comparator operand width.
DEBOUNCE_CYCLES, 16, number of consecutive clk cycles the synchronised button must differ from its debounced level before the debounced level changes; minimum 1.
TIMEOUT_CYCLES, 1024, number of idle cycles in ESPERA_B before the block abandons a half-loaded pair; used only with CARGADOR_TIMEOUT_EN.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
sw  input  WIDTH  operand value from switches; asynchronous to clk, and must be stable while the button is pressed.
btn  input  1  raw push-button, active-high, bouncy and asynchronous.
A  output  WIDTH  registered operand A; connects to comparator A, MSB to MSB.
B  output  WIDTH  registered operand B; connects to comparator B, MSB to MSB (comparator B is declared [0:2], so the connection is positional).
valido  output  1  high while A and B form a complete, current pair.
estado  output  2  current FSM state for LEDs/debug: 00 ESPERA_A, 01 ESPERA_B, 10 LISTO; 11 is never driven.

Behaviour:
- Interface: one clock `clk`. Reset `rst` is synchronous and active-high. No asynchronous reset anywhere.
- Reset, on a rising clk edge with rst=1:
  - A=0, B=0, valido=0, estado=ESPERA_A.
  - Synchroniser flops, debounced level, its delayed copy and the debounce counter are all cleared to 0.
  - The timeout counter is cleared to 0.
  - rst has priority over every other event, including mid-debounce and mid-pair; any partial operand is discarded.
- Synchroniser: two-flop chain btn→s1→s2.
- Debounce:
  - The counter clears whenever s2 equals the debounced level.
  - Otherwise it increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and s2 still differs, the debounced level takes s2 and the counter clears.
  - Pulses shorter than DEBOUNCE_CYCLES cycles at s2 are rejected.
- Press pulse:
  - pulsa = debounced & ~debounced_d, where debounced_d is the debounced level delayed one cycle. It is one cycle wide.
  - Release edges generate nothing.
  - A press held for any length produces exactly one pulse.
- Latency: btn first sampled high at edge 1 → A (or B) updates at edge DEBOUNCE_CYCLES+3.
- FSM (acts only on edges where pulsa=1; otherwise it holds):
  - ESPERA_A: A←sw, go to ESPERA_B; valido stays 0.
  - ESPERA_B: B←sw, go to LISTO; valido←1 on the same edge.
  - LISTO: A←sw, valido←0, go to ESPERA_B; B keeps its old value but is invalid.
- Output rules:
  - A, B and valido are registers; there is no combinational path from sw or btn to any output.
  - sw is sampled only on capture edges. Switch changes outside a capture do not alter A or B.
  - valido is high iff estado=LISTO.

Optional Feature:
- Macro: CARGADOR_TIMEOUT_EN.
- With the macro defined:
  - A timeout counter runs only in ESPERA_B. It clears on entry to ESPERA_B and on any pulsa.
  - If it reaches TIMEOUT_CYCLES-1 with no pulsa, the next edge returns the FSM to ESPERA_A, clears A to 0 and keeps valido=0.
  - If pulsa and timeout occur on the same edge, pulsa wins: B is captured and the FSM goes to LISTO.
- Without the macro: no timeout counter is built, ESPERA_B waits indefinitely, and TIMEOUT_CYCLES is ignored.

Test Plan:
1. Reset: assert rst for 2 edges while btn=1 and sw=3'b111 → A=0, B=0, valido=0, estado=00; no pulse for DEBOUNCE_CYCLES+3 edges after release of rst unless btn is held.
2. Load sequence (DEBOUNCE_CYCLES=4):
   - sw=3'b101, btn high 10 cycles → A=5 at edge 7 after the first btn-high sample, estado=01.
   - sw=3'b011, second press → B=3, valido=1, estado=10; the comparator shows A>B.
3. Bounce rejection (DEBOUNCE_CYCLES=4): btn toggling high 3 cycles / low 1 cycle for 20 cycles, then low → no state change, estado=00, A=0.
4. Reload from LISTO: with A=5, B=3, valido=1, sw=3'b010 and a press → A=2, valido=0, estado=01, B still 3; sw changes with no press leave A=2.
5. Mid-operation reset: rst asserted while in ESPERA_B with the debounce counter at 2 → next edge A=0, B=0, estado=00; the held button must re-debounce fully before any capture.
6. Timeout (CARGADOR_TIMEOUT_EN, TIMEOUT_CYCLES=8):
   - Load A=6, then idle → estado=00 and A=0 after 8 cycles in ESPERA_B.
   - A press pulse landing on cycle 8 → B captured, estado=10.
   - Without the macro, the same idle for 100 cycles → estado stays 01, A=6.
